// File: rtl/bp_pkg.sv
// Shared types, defaults and helpers for the branch predictor.
// Optional build macro: BP_GSHARE_EN (gshare indexing; bimodal when undefined).
package bp_pkg;

  localparam int PHT_IDX_W_DFLT = 8;
  localparam int BTB_IDX_W_DFLT = 4;

  // Weakly not-taken
  localparam logic [1:0] PHT_RESET = 2'b01;

  // Tag field is sized for the smallest possible index; unused MSBs stay zero
  localparam int BTB_TAG_W = 30;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [31:0]          target;
  } btb_entry_t;

  // 2-bit saturating counter step, bounded at 00 and 11
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != 2'b11) nxt = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00) nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: combinational lookup, synchronous
// write and valid-bit invalidate. Tags and targets carry no reset.
module bp_btb
  import bp_pkg::*;
#(
  parameter int IDX_W = BTB_IDX_W_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_lk_pc,
  output logic        o_hit,
  output logic [31:0] o_target,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_pc,
  input  logic [31:0] i_wr_target
);

  localparam int unsigned N = 1 << IDX_W;

  btb_entry_t           r_mem [N];

  logic [29:0]          w_lk_word;
  logic [29:0]          w_wr_word;
  logic [IDX_W-1:0]     w_lk_idx;
  logic [IDX_W-1:0]     w_wr_idx;
  logic [BTB_TAG_W-1:0] w_lk_tag;
  logic [BTB_TAG_W-1:0] w_wr_tag;
  btb_entry_t           w_rd;
  logic                 w_unused_lo;

  assign w_lk_word   = i_lk_pc[31:2];
  assign w_wr_word   = i_wr_pc[31:2];
  assign w_lk_idx    = w_lk_word[IDX_W-1:0];
  assign w_wr_idx    = w_wr_word[IDX_W-1:0];
  // Tag is the word address above the index, zero-extended into the tag field
  assign w_lk_tag    = w_lk_word >> IDX_W;
  assign w_wr_tag    = w_wr_word >> IDX_W;
  assign w_unused_lo = ^{i_lk_pc[1:0], i_wr_pc[1:0]};

  // Lookup: hit on valid entry with matching tag; target forced to 0 on miss
  always_comb begin
    w_rd     = r_mem[w_lk_idx];
    o_hit    = w_rd.valid && (w_rd.tag == w_lk_tag);
    o_target = o_hit ? w_rd.target : '0;
  end

  // Reset clears only valid bits; a write overwrites any aliasing entry
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        r_mem[i].valid <= 1'b0;
      end
    end else if (i_wr_en) begin
      r_mem[w_wr_idx] <= '{valid: 1'b1, tag: w_wr_tag, target: i_wr_target};
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Gshare / bimodal direction predictor with a direct-mapped BTB.
// Build macro BP_GSHARE_EN: defined selects PC^GHR indexing with a
// non-speculative GHR; undefined selects bimodal PC-only indexing.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PHT_IDX_W = PHT_IDX_W_DFLT,
  parameter int BTB_IDX_W = BTB_IDX_W_DFLT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          F_PC,
  output logic                 F_pred_taken,
  output logic [PHT_IDX_W-1:0] F_pht_idx,
  output logic                 F_btb_hit,
  output logic [31:0]          F_btb_target,
  input  logic                 ex_update_en,
  input  logic                 ex_actual_taken,
  input  logic [31:0]          ex_pc,
  input  logic [31:0]          ex_actual_target,
  input  logic [PHT_IDX_W-1:0] pht_idx_ex
);

  localparam int unsigned PHT_N = 1 << PHT_IDX_W;

  logic [1:0]           r_pht [PHT_N];
  logic [PHT_IDX_W-1:0] w_ghr;
  logic [PHT_IDX_W-1:0] w_pc_idx;
  logic                 w_btb_hit;
  logic [31:0]          w_btb_target;

`ifdef BP_GSHARE_EN
  logic [PHT_IDX_W-1:0] r_ghr;

  // Non-speculative global history, shifted on every resolved update
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ghr <= '0;
    end else if (ex_update_en) begin
      r_ghr <= {r_ghr[PHT_IDX_W-2:0], ex_actual_taken};
    end
  end

  assign w_ghr = r_ghr;
`else
  assign w_ghr = '0;
`endif

  assign w_pc_idx = F_PC[PHT_IDX_W+1:2];

  // Lookup: index formation and direction qualified by BTB hit
  always_comb begin
    F_pht_idx    = w_pc_idx ^ w_ghr;
    F_btb_hit    = w_btb_hit;
    F_btb_target = w_btb_target;
    F_pred_taken = r_pht[F_pht_idx][1] & w_btb_hit;
  end

  // PHT training; reset wins over a coincident update
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < PHT_N; i++) begin
        r_pht[i] <= PHT_RESET;
      end
    end else if (ex_update_en) begin
      r_pht[pht_idx_ex] <= sat_update(r_pht[pht_idx_ex], ex_actual_taken);
    end
  end

  bp_btb #(
    .IDX_W (BTB_IDX_W)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .i_lk_pc     (F_PC),
    .o_hit       (w_btb_hit),
    .o_target    (w_btb_target),
    .i_wr_en     (ex_update_en & ex_actual_taken),
    .i_wr_pc     (ex_pc),
    .i_wr_target (ex_actual_target)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
module tb_branch_predictor;

`ifdef BP_GSHARE_EN
  localparam bit          GS  = 1'b1;
  localparam logic [31:0] P_L = 32'h0000_00BC;
  localparam logic [31:0] Q_L = 32'h0000_01B8;
`else
  localparam bit          GS  = 1'b0;
  localparam logic [31:0] P_L = 32'h0000_0040;
  localparam logic [31:0] Q_L = 32'h0000_0040;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] F_PC;
  logic        F_pred_taken;
  logic [7:0]  F_pht_idx;
  logic        F_btb_hit;
  logic [31:0] F_btb_target;
  logic        ex_update_en;
  logic        ex_actual_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_actual_target;
  logic [7:0]  pht_idx_ex;

  logic [7:0]  ghr_m;
  int          n_checks;
  int          n_errors;

  branch_predictor #(
    .PHT_IDX_W (8),
    .BTB_IDX_W (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .F_PC             (F_PC),
    .F_pred_taken     (F_pred_taken),
    .F_pht_idx        (F_pht_idx),
    .F_btb_hit        (F_btb_hit),
    .F_btb_target     (F_btb_target),
    .ex_update_en     (ex_update_en),
    .ex_actual_taken  (ex_actual_taken),
    .ex_pc            (ex_pc),
    .ex_actual_target (ex_actual_target),
    .pht_idx_ex       (pht_idx_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_idx(input logic [31:0] pc);
    return pc[9:2] ^ (GS ? ghr_m : 8'h00);
  endfunction

  task automatic upd(input logic [31:0] pc, input logic tk,
                     input logic [31:0] tgt, input logic [7:0] idx);
    @(negedge clk);
    ex_update_en     = 1'b1;
    ex_actual_taken  = tk;
    ex_pc            = pc;
    ex_actual_target = tgt;
    pht_idx_ex       = idx;
    @(posedge clk);
    #1;
    ex_update_en = 1'b0;
    ghr_m = {ghr_m[6:0], tk};
  endtask

  task automatic look(input logic [31:0] pc);
    @(negedge clk);
    F_PC = pc;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst   = 1'b1;
    ghr_m = 8'h00;
    look(32'h100);
    n_checks++; if (F_btb_hit !== 1'b0) begin n_errors++; $display("FAIL rst_hit got %0h want 0", F_btb_hit); end
    n_checks++; if (F_pred_taken !== 1'b0) begin n_errors++; $display("FAIL rst_pred got %0h want 0", F_pred_taken); end
    n_checks++; if (F_btb_target !== 32'h0) begin n_errors++; $display("FAIL rst_target got %0h want 0", F_btb_target); end
    n_checks++; if (F_pht_idx !== 8'h40) begin n_errors++; $display("FAIL rst_idx got %0h want 40", F_pht_idx); end
  endtask

  task automatic test_first_update();
    upd(32'h100, 1'b1, 32'h200, 8'h40);
    look(32'h100);
    n_checks++; if (F_btb_hit !== 1'b1) begin n_errors++; $display("FAIL first_hit got %0h want 1", F_btb_hit); end
    n_checks++; if (F_btb_target !== 32'h200) begin n_errors++; $display("FAIL first_target got %0h want 200", F_btb_target); end
    n_checks++; if (F_pht_idx !== (GS ? 8'h41 : 8'h40)) begin n_errors++; $display("FAIL first_idx got %0h want %0h", F_pht_idx, (GS ? 8'h41 : 8'h40)); end
    // gshare reads untouched counter[0x41]=01; bimodal reads trained counter[0x40]=10
    n_checks++; if (F_pred_taken !== (GS ? 1'b0 : 1'b1)) begin n_errors++; $display("FAIL first_pred got %0h want %0h", F_pred_taken, (GS ? 1'b0 : 1'b1)); end
  endtask

  task automatic test_saturation();
    upd(Q_L, 1'b1, 32'h600, 8'h99);
    for (int i = 0; i < 4; i++) upd(P_L, 1'b1, 32'h500, 8'h10);
    look(P_L);
    n_checks++; if (F_pht_idx !== 8'h10) begin n_errors++; $display("FAIL sat_idx got %0h want 10", F_pht_idx); end
    n_checks++; if (F_btb_hit !== 1'b1) begin n_errors++; $display("FAIL sat_hit got %0h want 1", F_btb_hit); end
    n_checks++; if (F_pred_taken !== 1'b1) begin n_errors++; $display("FAIL sat_pred11 got %0h want 1", F_pred_taken); end
    upd(32'h0, 1'b0, 32'h0, 8'h10);
    look(Q_L);
    n_checks++; if (F_pht_idx !== 8'h10) begin n_errors++; $display("FAIL sat_idx2 got %0h want 10", F_pht_idx); end
    n_checks++; if (F_pred_taken !== 1'b1) begin n_errors++; $display("FAIL sat_pred10 got %0h want 1", F_pred_taken); end
  endtask

  task automatic test_alias();
    upd(32'h100, 1'b1, 32'h200, 8'h00);
    upd(32'h140, 1'b1, 32'h300, 8'h00);
    look(32'h100);
    n_checks++; if (F_btb_hit !== 1'b0) begin n_errors++; $display("FAIL alias_old_hit got %0h want 0", F_btb_hit); end
    look(32'h140);
    n_checks++; if (F_btb_hit !== 1'b1) begin n_errors++; $display("FAIL alias_new_hit got %0h want 1", F_btb_hit); end
    n_checks++; if (F_btb_target !== 32'h300) begin n_errors++; $display("FAIL alias_target got %0h want 300", F_btb_target); end
    n_checks++; if (F_pht_idx !== exp_idx(32'h140)) begin n_errors++; $display("FAIL alias_idx got %0h want %0h", F_pht_idx, exp_idx(32'h140)); end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    F_PC             = 32'h180;
    ex_update_en     = 1'b1;
    ex_actual_taken  = 1'b1;
    ex_pc            = 32'h180;
    ex_actual_target = 32'h400;
    pht_idx_ex       = 8'h01;
    #1;
    n_checks++; if (F_btb_hit !== 1'b0) begin n_errors++; $display("FAIL rw_old_hit got %0h want 0", F_btb_hit); end
    n_checks++; if (F_btb_target !== 32'h0) begin n_errors++; $display("FAIL rw_old_target got %0h want 0", F_btb_target); end
    @(posedge clk);
    #1;
    ex_update_en = 1'b0;
    ghr_m = {ghr_m[6:0], 1'b1};
    look(32'h180);
    n_checks++; if (F_btb_hit !== 1'b1) begin n_errors++; $display("FAIL rw_new_hit got %0h want 1", F_btb_hit); end
    n_checks++; if (F_btb_target !== 32'h400) begin n_errors++; $display("FAIL rw_new_target got %0h want 400", F_btb_target); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rst              = 1'b0;
    ex_update_en     = 1'b1;
    ex_actual_taken  = 1'b1;
    ex_pc            = 32'h200;
    ex_actual_target = 32'h700;
    pht_idx_ex       = 8'h80;
    @(posedge clk);
    #1;
    rst          = 1'b1;
    ex_update_en = 1'b0;
    ghr_m        = 8'h00;
    look(32'h180);
    n_checks++; if (F_btb_hit !== 1'b0) begin n_errors++; $display("FAIL mid_hit180 got %0h want 0", F_btb_hit); end
    n_checks++; if (F_pht_idx !== 8'h60) begin n_errors++; $display("FAIL mid_idx180 got %0h want 60", F_pht_idx); end
    look(P_L);
    n_checks++; if (F_btb_hit !== 1'b0) begin n_errors++; $display("FAIL mid_hitP got %0h want 0", F_btb_hit); end
    n_checks++; if (F_pred_taken !== 1'b0) begin n_errors++; $display("FAIL mid_predP got %0h want 0", F_pred_taken); end
    look(32'h200);
    n_checks++; if (F_btb_hit !== 1'b0) begin n_errors++; $display("FAIL mid_drop_hit got %0h want 0", F_btb_hit); end
    n_checks++; if (F_btb_target !== 32'h0) begin n_errors++; $display("FAIL mid_drop_target got %0h want 0", F_btb_target); end
    n_checks++; if (F_pht_idx !== 8'h80) begin n_errors++; $display("FAIL mid_idx200 got %0h want 80", F_pht_idx); end
  endtask

  initial begin
    n_checks         = 0;
    n_errors         = 0;
    ghr_m            = 8'h00;
    rst              = 1'b0;
    F_PC             = 32'h0;
    ex_update_en     = 1'b0;
    ex_actual_taken  = 1'b0;
    ex_pc            = 32'h0;
    ex_actual_target = 32'h0;
    pht_idx_ex       = 8'h00;
    test_reset();
    test_first_update();
    test_saturation();
    test_alias();
    test_same_cycle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

- Gshare direction predictor (2-bit counter PHT) plus a direct-mapped branch target buffer.
- Sits directly upstream of the fetch PC mux. It looks up the current fetch PC in the same cycle and returns taken/target hints that travel down the pipe with the instruction.
- It is trained by the execute stage when a control-transfer instruction resolves.

## Interface
Parameters:
- PHT_IDX_W, 8, PHT index width; PHT has 2^PHT_IDX_W entries; GHR has this width.
- BTB_IDX_W, 4, BTB index width; BTB has 2^BTB_IDX_W entries.

Ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- F_PC  in  32  fetch PC being looked up.
- F_pred_taken  out  1  predict taken; equals PHT counter MSB AND F_btb_hit.
- F_pht_idx  out  PHT_IDX_W  PHT index used for this lookup; carried down the pipe and returned as pht_idx_ex.
- F_btb_hit  out  1  BTB entry valid and tag match.
- F_btb_target  out  32  stored target on hit, 0 on miss.
- ex_update_en  in  1  one-cycle pulse per resolved branch/JAL/JALR in EX.
- ex_actual_taken  in  1  resolved direction; 1 for jumps.
- ex_pc  in  32  PC of the resolved instruction.
- ex_actual_target  in  32  resolved target.
- pht_idx_ex  in  PHT_IDX_W  index captured at fetch for that instruction.

## Operation
- **Lookup:** purely combinational from F_PC and the current state.
  - PC[1:0] are ignored.
  - F_pht_idx = F_PC[PHT_IDX_W+1:2] XOR GHR.
  - BTB index = F_PC[BTB_IDX_W+1:2]; tag = F_PC[31:BTB_IDX_W+2].
- **PHT update**, when ex_update_en=1: PHT[pht_idx_ex] saturating +1 if taken, -1 if not.
  - Counter bounds are 00 and 11.
  - Prediction is taken when the counter MSB is 1.
- **GHR update**, when ex_update_en=1: GHR <= {GHR[PHT_IDX_W-2:0], ex_actual_taken}.
  - History is non-speculative and is never rolled back.
- **BTB update:** only on ex_update_en=1 with ex_actual_taken=1.
  - Writes entry[ex_pc index] = {valid=1, tag(ex_pc), ex_actual_target}.
  - Overwrites any aliasing entry.
  - Not-taken updates leave the BTB unchanged.
- **Reset** (rst=0 at an edge):
  - All PHT counters set to 01 (weakly not-taken).
  - GHR set to 0.
  - All BTB valid bits cleared; BTB tags and targets need no reset.
  - Reset takes priority over a coincident update, which is dropped.
- **Reset values of outputs** after the reset edge: F_pred_taken=0, F_btb_hit=0, F_btb_target=0, F_pht_idx=F_PC[PHT_IDX_W+1:2].
- No stall input. Lookups are stateless, and the fetch/FD pipeline holds F_* while stalled.

## Timing
- Lookup latency is 0 cycles: outputs follow F_PC combinationally.
- An update takes effect at the edge where ex_update_en=1. Lookups in the same cycle see the old state; lookups from the next cycle see the new state.
- Same-entry read and write in one cycle: the read returns the pre-update value, with no bypass.
- Back-to-back updates on consecutive cycles are all applied, including to the same PHT index (counter steps once per cycle).
- Reset asserted mid-operation discards all training at the next edge.

## Configuration
- Macro: BP_GSHARE_EN.
- Defined: index is PC bits XOR GHR, and the GHR is maintained as above.
- Undefined: bimodal mode.
  - Index is F_PC[PHT_IDX_W+1:2] only.
  - No GHR register is synthesized; GHR reads as 0.
  - All other behaviour is identical.

## Structure
- Shared package bp_pkg holds:
  - PHT_IDX_W and BTB_IDX_W defaults.
  - PHT_RESET counter constant 2'b01.
  - typedef btb_entry_t {valid, tag, target}.
  - Saturating-counter update function.
- One sub-module, bp_btb: the BTB array with combinational lookup and synchronous write/invalidate.
- The PHT and GHR live in branch_predictor.

## Test plan
All scenarios use the default parameters with BP_GSHARE_EN defined.

1. **Reset:** hold rst=0 for one edge, then F_PC=0x100.
   - Expect F_btb_hit=0, F_pred_taken=0, F_btb_target=0, F_pht_idx=0x40.
2. **First taken update:** pulse ex_update_en with ex_pc=0x100, taken, ex_actual_target=0x200, pht_idx_ex=0x40. Next cycle F_PC=0x100.
   - Expect F_btb_hit=1, F_btb_target=0x200.
   - GHR=0x01, so F_pht_idx=0x41 and counter[0x41]=01, giving F_pred_taken=0.
   - Counter[0x40]=10.
3. **Saturation:** four taken updates at pht_idx_ex=0x10, then one not-taken. Drive F_PC so that PC[9:2]^GHR=0x10 with a BTB hit.
   - Expect counter 11 after the taken updates, then 10; F_pred_taken stays 1.
4. **BTB aliasing:** train 0x100 to target 0x200, then train 0x140 (same index, different tag) to target 0x300.
   - F_PC=0x100 gives F_btb_hit=0.
   - F_PC=0x140 gives hit with target 0x300.
5. **Same-cycle read/write:** F_PC=0x180 (untrained) while updating ex_pc=0x180 taken, target 0x400.
   - Expect F_btb_hit=0 that cycle and 1 with target 0x400 the next cycle.
6. **Reset mid-operation:** after scenarios 2–4, assert rst=0 together with a taken update.
   - Expect all lookups to miss and F_pred_taken=0.
   - Expect F_pht_idx=PC[9:2] (GHR=0); the update is dropped.
